hps_dma_bridge: RTL and testbench

HPS_DMA_BRIDGE -- requirements
Module: hps_dma_bridge

---
 rtl/hps_dma_bridge.sv | 189 ++++++++++++++++++
 tb/tb_hps_dma_bridge.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/hps_dma_bridge.sv
// rtl/hps_dma_bridge.sv - HPS-to-Avalon DMA bridge with a burst read-prefetch buffer
// Optional read watchdog: define HPS_DMA_BRIDGE_TIMEOUT_EN to build it (err tied low otherwise).
// Single-word HPS requests are served from a BURST-word buffer on a hit, or by an
// Avalon burst that refills the buffer on a miss. Writes go straight through as
// single-beat Avalon writes and patch the buffer when they hit it.
module hps_dma_bridge #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int BURST   = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [AW-1:0]     dma_addr,
  input  logic              dma_rd,
  input  logic              dma_wr,
  input  logic [DW-1:0]     dma_dout,
  output logic [DW-1:0]     dma_din,
  output logic              io_wait,
  output logic              err,
  output logic [AW-1:0]     avm_address,
  output logic [4:0]        avm_burstcount,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DW-1:0]     avm_writedata,
  output logic [DW/8-1:0]   avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid,
  input  logic [DW-1:0]     avm_readdata
);

  localparam int OFFB = $clog2(DW / 8);
  localparam int WIW  = AW - OFFB;
  localparam int BB   = $clog2(BURST);
  localparam int BIW  = (BB > 0) ? BB : 1;
  localparam int BCW  = BB + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HIT     = 3'd1;
  localparam logic [2:0] S_RD_REQ  = 3'd2;
  localparam logic [2:0] S_RD_DATA = 3'd3;
  localparam logic [2:0] S_WR_REQ  = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [WIW-1:0] BASE_MASK = ~WIW'(BURST - 1);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST - 1);

  logic [2:0]     state_q, state_d;
  logic           io_wait_q;
  logic [DW-1:0]  dma_din_q;
  logic           valid_q;
  logic [WIW-1:0] base_q;
  logic [WIW-1:0] req_idx_q;
  logic [BIW-1:0] req_off_q;
  logic [DW-1:0]  wdata_q;
  logic [BCW-1:0] beat_q;
  logic [DW-1:0]  buf_mem_q [BURST];

  logic [WIW-1:0] addr_idx;
  logic [WIW-1:0] addr_base;
  logic [BIW-1:0] addr_off;
  logic [WIW-1:0] req_base;
  logic [BIW-1:0] beat_slot;
  logic           addr_hit;
  logic           beat_in;
  logic           last_beat;
  logic           to_fire;

  assign addr_idx  = dma_addr[AW-1:OFFB];
  assign addr_base = addr_idx & BASE_MASK;
  assign addr_off  = BIW'(addr_idx % WIW'(BURST));
  assign req_base  = req_idx_q & BASE_MASK;
  assign beat_slot = beat_q[BIW-1:0];
  assign addr_hit  = valid_q && (addr_base == base_q);
  // Beats outside RD_DATA are stray (e.g. the tail of a burst cut short by reset).
  assign beat_in   = (state_q == S_RD_DATA) && avm_readdatavalid;
  assign last_beat = beat_in && (beat_q == LAST_BEAT);

`ifdef HPS_DMA_BRIDGE_TIMEOUT_EN
  logic [31:0] to_cnt_q;
  logic        err_q;
  logic        rd_active;

  assign rd_active = (state_q == S_RD_REQ) || (state_q == S_RD_DATA);
  assign to_fire   = rd_active && (to_cnt_q == 32'(TIMEOUT - 1));
  assign err       = err_q;

  // Watchdog: counts cycles spent waiting on the read; err is sticky until the next request.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= (rd_active && !to_fire) ? to_cnt_q + 32'd1 : '0;
      if (state_q == S_IDLE && (dma_rd || dma_wr)) err_q <= 1'b0;
      if (to_fire) err_q <= 1'b1;
    end
  end
`else
  assign to_fire = 1'b0;
  assign err     = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, dma_addr[OFFB-1:0], (TIMEOUT != 0)};

  // Next-state decode; a watchdog expiry overrides whatever the read was doing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (dma_wr)      state_d = S_WR_REQ;
        else if (dma_rd) state_d = addr_hit ? S_HIT : S_RD_REQ;
      end
      S_HIT:     state_d = S_DONE;
      S_RD_REQ:  if (!avm_waitrequest) state_d = S_RD_DATA;
      S_RD_DATA: if (last_beat) state_d = S_DONE;
      S_WR_REQ:  if (!avm_waitrequest) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (to_fire) state_d = S_DONE;
  end

  // Control and result registers: request capture, beat counting, buffer tag and io_wait.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= S_IDLE;
      io_wait_q <= 1'b0;
      dma_din_q <= '0;
      valid_q   <= 1'b0;
      base_q    <= '0;
      req_idx_q <= '0;
      req_off_q <= '0;
      wdata_q   <= '0;
      beat_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (dma_wr || dma_rd) begin
            io_wait_q <= 1'b1;
            req_idx_q <= addr_idx;
            req_off_q <= addr_off;
            wdata_q   <= dma_dout;
            // A miss refills the buffer, so its old contents stop being trustworthy now.
            if (!dma_wr && !addr_hit) valid_q <= 1'b0;
          end
        end
        S_HIT: dma_din_q <= buf_mem_q[req_off_q];
        S_RD_DATA: begin
          if (beat_in) begin
            if (beat_slot == req_off_q) dma_din_q <= avm_readdata;
            if (last_beat) begin
              valid_q <= 1'b1;
              base_q  <= req_base;
              beat_q  <= '0;
            end else begin
              beat_q <= beat_q + BCW'(1);
            end
          end
        end
        S_DONE: io_wait_q <= 1'b0;
        default: ;
      endcase
      if (to_fire) begin
        dma_din_q <= '1;
        valid_q   <= 1'b0;
        beat_q    <= '0;
      end
    end
  end

  // Buffer storage: filled by burst beats, patched by writes that hit the cached line.
  always_ff @(posedge clk_sys) begin
    if (state_q == S_IDLE && dma_wr && addr_hit) buf_mem_q[addr_off] <= dma_dout;
    else if (beat_in) buf_mem_q[beat_slot] <= avm_readdata;
  end

  assign dma_din        = dma_din_q;
  assign io_wait        = io_wait_q;
  assign avm_read       = (state_q == S_RD_REQ);
  assign avm_write      = (state_q == S_WR_REQ);
  assign avm_address    = {(avm_read ? req_base : req_idx_q), {OFFB{1'b0}}};
  assign avm_burstcount = avm_read ? 5'(BURST) : 5'd1;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = '1;

endmodule

// File: tb/tb_hps_dma_bridge.sv
// tb/tb_hps_dma_bridge.sv - randomized bench for hps_dma_bridge against a memory/cache reference model
module tb_hps_dma_bridge;

  localparam int DW      = 32;
  localparam int AW      = 32;
  localparam int BURST   = 4;
  localparam int TIMEOUT = 16;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic [AW-1:0] dma_addr;
  logic          dma_rd, dma_wr;
  logic [DW-1:0] dma_dout, dma_din;
  logic          io_wait, err;
  logic [AW-1:0] avm_address;
  logic [4:0]    avm_burstcount;
  logic          avm_read, avm_write;
  logic [DW-1:0] avm_writedata;
  logic [3:0]    avm_byteenable;
  logic          avm_waitrequest, avm_readdatavalid;
  logic [DW-1:0] avm_readdata;

  hps_dma_bridge #(.DW(DW), .AW(AW), .BURST(BURST), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .dma_addr(dma_addr), .dma_rd(dma_rd), .dma_wr(dma_wr), .dma_dout(dma_dout),
    .dma_din(dma_din), .io_wait(io_wait), .err(err),
    .avm_address(avm_address), .avm_burstcount(avm_burstcount),
    .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
    .avm_readdata(avm_readdata)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: flat word memory plus the bridge's cached line (valid + base word index).
  logic [31:0] mem [0:1023];
  bit          m_valid;
  int          m_base;

  int          n_bursts, n_writes, burst_addr, burst_bc, wr_addr, wr_bc, wait_cycles;
  logic [31:0] wr_data;
  bit          both_seen;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_valid = 1'b0;
  endtask

  // One HPS request; the bench plays the Avalon slave until io_wait drops or the budget runs out.
  task automatic run_op(input bit rd, input bit wr, input int addr, input logic [31:0] data,
                        input int budget, input bit mute);
    int beats_left = 0;
    int k = 0;
    int bbase = 0;
    int stalls = 0;
    bit acc = 1'b0;
    n_bursts = 0; n_writes = 0; wait_cycles = 0; both_seen = 1'b0;
    dma_addr = addr; dma_rd = rd; dma_wr = wr; dma_dout = data;
    tick();
    dma_rd = 1'b0; dma_wr = 1'b0;
    while (io_wait && wait_cycles < budget) begin
      wait_cycles++;
      if (avm_read && avm_write) both_seen = 1'b1;
      avm_readdatavalid = 1'b0;
      if (acc && beats_left > 0 && !mute) begin
        if (stalls < 4 && $urandom_range(0, 3) == 0) stalls++;
        else begin
          avm_readdatavalid = 1'b1;
          avm_readdata = mem[bbase + k];
          k++;
          beats_left--;
        end
      end
      avm_waitrequest = 1'b0;
      if (stalls < 4 && $urandom_range(0, 3) == 0) begin
        avm_waitrequest = 1'b1;
        stalls++;
      end
      if (avm_read && !avm_waitrequest) begin
        n_bursts++;
        burst_addr = int'(avm_address);
        burst_bc = int'(avm_burstcount);
        bbase = int'(avm_address >> 2);
        beats_left = int'(avm_burstcount);
        k = 0;
        acc = 1'b1;
      end
      if (avm_write && !avm_waitrequest) begin
        n_writes++;
        wr_addr = int'(avm_address);
        wr_bc = int'(avm_burstcount);
        wr_data = avm_writedata;
        mem[avm_address >> 2] = avm_writedata;
      end
      tick();
    end
    avm_readdatavalid = 1'b0;
    avm_waitrequest = 1'b0;
  endtask

  task automatic model_read(input int addr);
    int idx = addr >> 2;
    int base = (idx / BURST) * BURST;
    bit hit = m_valid && (base == m_base);
    run_op(1'b1, 1'b0, addr, 32'h0, 200, 1'b0);
    check_eq("rd_data", dma_din, mem[idx]);
    check_eq("rd_bursts", n_bursts, hit ? 0 : 1);
    if (hit) check_eq("hit_wait", wait_cycles, 2);
    else begin
      check_eq("rd_burst_addr", burst_addr, base * 4);
      check_eq("rd_burstcount", burst_bc, BURST);
      m_valid = 1'b1;
      m_base = base;
    end
    check_eq("rd_no_write", n_writes, 0);
    check_eq("rd_rw_excl", both_seen, 0);
  endtask

  task automatic model_write(input int addr, input logic [31:0] data, input bit with_rd);
    run_op(with_rd, 1'b1, addr, data, 200, 1'b0);
    check_eq("wr_count", n_writes, 1);
    check_eq("wr_addr", wr_addr, (addr >> 2) * 4);
    check_eq("wr_data", wr_data, data);
    check_eq("wr_burstcount", wr_bc, 1);
    check_eq("wr_no_read", n_bursts, 0);
    check_eq("wr_rw_excl", both_seen, 0);
  endtask

  initial begin
    reset = 1'b1; dma_addr = '0; dma_rd = 1'b0; dma_wr = 1'b0; dma_dout = '0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[64 + i] = 32'hA0 + 32'(i);
    tick(); tick();
    do_reset();

    check_eq("rst_io_wait", io_wait, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_din", dma_din, 0);
    check_eq("rst_avm_read", avm_read, 0);
    check_eq("rst_avm_write", avm_write, 0);
    check_eq("byteenable", avm_byteenable, 4'hF);

    model_read(32'h100);
    check_eq("dir_rd100", dma_din, 32'hA0);
    model_read(32'h10C);
    check_eq("dir_rd10c", dma_din, 32'hA3);
    model_write(32'h104, 32'h55, 1'b0);
    model_read(32'h104);
    check_eq("dir_rd104", dma_din, 32'h55);
    model_write(32'h200, 32'h1234_5678, 1'b1);

    for (int n = 0; n < 60; n++) begin
      int a = int'($urandom_range(0, 255)) * 4 + int'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: model_write(a, $urandom, 1'b0);
        1: model_write(a, $urandom, 1'b1);
        default: model_read(a);
      endcase
    end

    // Reset in the middle of a burst: the late beats must not reach the buffer.
    do_reset();
    dma_addr = 32'h100; dma_rd = 1'b1;
    tick();
    dma_rd = 1'b0;
    check_eq("mid_avm_read", avm_read, 1);
    tick();
    avm_readdatavalid = 1'b1; avm_readdata = 32'hDEAD0000;
    tick();
    avm_readdata = 32'hDEAD0001;
    tick();
    avm_readdatavalid = 1'b0;
    do_reset();
    check_eq("mid_rst_io_wait", io_wait, 0);
    check_eq("mid_rst_din", dma_din, 0);
    check_eq("mid_rst_avm_read", avm_read, 0);
    avm_readdatavalid = 1'b1; avm_readdata = 32'hDEAD0002;
    tick();
    avm_readdata = 32'hDEAD0003;
    tick();
    avm_readdatavalid = 1'b0;
    check_eq("late_io_wait", io_wait, 0);
    model_read(32'h100);

    // Read that never receives data.
    run_op(1'b1, 1'b0, 32'h300, 32'h0, 40, 1'b1);
`ifdef HPS_DMA_BRIDGE_TIMEOUT_EN
    check_eq("to_latency", (wait_cycles >= 17 && wait_cycles <= 18), 1);
    check_eq("to_err", err, 1);
    check_eq("to_din", dma_din, 32'hFFFF_FFFF);
    m_valid = 1'b0;
    model_read(32'h104);
    check_eq("to_err_clear", err, 0);
`else
    check_eq("nto_wait", wait_cycles, 40);
    check_eq("nto_io_wait", io_wait, 1);
    check_eq("nto_err", err, 0);
    do_reset();
    model_read(32'h104);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
